// File: rtl/sm4_pkg.sv
// Shared SM4 constants, transforms and FSM state types for the iterative engine.
// The S-box is stored flat with entry 0 in the most significant byte.
package sm4_pkg;

    typedef enum logic {
        KEY_IDLE,
        KEY_EXPAND
    } key_state_e;

    typedef enum logic [1:0] {
        BLK_IDLE,
        BLK_WAIT_KEY,
        BLK_RUN,
        BLK_DONE
    } blk_state_e;

    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [2047:0] SBOX_FLAT = {
        128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
        128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
        128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
        128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
        128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
        128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
        128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
        128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[{~x, 3'b000} +: 8];
    endfunction

    // CK_i byte j is ((4i+j)*7) mod 256, most significant byte first.
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] c;
        logic [7:0]  n;
        c = '0;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, i, 2'b00} + 8'(j);
            c = {c[23:0], 8'(n * 8'd7)};
        end
        return c;
    endfunction

    function automatic logic [31:0] l_rnd(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// Single 8-bit SM4 substitution box, purely combinational.
module sm4_sbox
    import sm4_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    assign y_o = sbox(a_i);

endmodule

// File: rtl/sm4_top.sv
// Iterative SM4 engine: one key-expansion round or one cipher round per cycle,
// with a 32-entry round-key store that persists across blocks.
module sm4_top
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         encdec_enable_in,
    input  logic         encdec_sel_in,
    input  logic         enable_key_exp_and_valid_data_in,
    input  logic [127:0] data_in,
    input  logic [127:0] user_key_in,
    output logic         ready_out,
    output logic [127:0] result_out,
    output logic         key_exp_ready_out,
    output logic         key_exp_ready_signal
);

    key_state_e   key_state_q, key_state_d;
    blk_state_e   blk_state_q, blk_state_d;
    logic [31:0]  rk_q [32];
    logic [31:0]  k_q [4];
    logic [31:0]  x_q [4];
    logic [4:0]   kcnt_q;
    logic [5:0]   bcnt_q;
    logic         dec_q;
    logic         key_ready_q;
    logic         key_sig_q;
    logic         ready_q;
    logic [127:0] result_q;
    logic         key_load_acc, start_acc;
    logic [4:0]   rk_idx;
    logic [31:0]  rnd_in, rnd_tau, rnd_new;
    logic [31:0]  key_in, key_tau, rk_new;

    // Handshake: a pulse is accepted only in the states listed below and ignored
    // otherwise; ready_out / key_exp_ready_out are levels held until cleared.
    assign key_load_acc = enable_key_exp_and_valid_data_in && (key_state_q == KEY_IDLE)
                          && (blk_state_q != BLK_RUN);
    assign start_acc    = encdec_enable_in
                          && (blk_state_q == BLK_IDLE || blk_state_q == BLK_DONE);

    assign rk_idx  = dec_q ? ~bcnt_q[4:0] : bcnt_q[4:0];
    assign rnd_in  = x_q[1] ^ x_q[2] ^ x_q[3] ^ rk_q[rk_idx];
    assign key_in  = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck(kcnt_q);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_rnd_sbox (.a_i(rnd_in[8*g +: 8]), .y_o(rnd_tau[8*g +: 8]));
        sm4_sbox u_key_sbox (.a_i(key_in[8*g +: 8]), .y_o(key_tau[8*g +: 8]));
    end

    assign rnd_new = x_q[0] ^ l_rnd(rnd_tau);
    assign rk_new  = k_q[0] ^ l_key(key_tau);

    always_ff @(posedge clk) begin
        if (reset_n) begin
            key_state_q <= KEY_IDLE;
            blk_state_q <= BLK_IDLE;
        end else begin
            key_state_q <= key_state_d;
            blk_state_q <= blk_state_d;
        end
    end

    always_comb begin
        key_state_d = key_state_q;
        blk_state_d = blk_state_q;
        case (key_state_q)
            KEY_IDLE:   if (key_load_acc) key_state_d = KEY_EXPAND;
            KEY_EXPAND: if (kcnt_q == 5'd31) key_state_d = KEY_IDLE;
            default:    key_state_d = KEY_IDLE;
        endcase
        // A key-load in the same cycle invalidates the current keys, so wait for the new ones.
        case (blk_state_q)
            BLK_IDLE, BLK_DONE: begin
                if (start_acc) begin
                    blk_state_d = (key_ready_q && !key_load_acc) ? BLK_RUN : BLK_WAIT_KEY;
                end
            end
            BLK_WAIT_KEY: if (key_ready_q && !key_load_acc) blk_state_d = BLK_RUN;
            BLK_RUN:      if (bcnt_q[5]) blk_state_d = BLK_DONE;
            default:      blk_state_d = BLK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 32; i++) rk_q[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                k_q[i] <= '0;
                x_q[i] <= '0;
            end
            kcnt_q      <= '0;
            bcnt_q      <= '0;
            dec_q       <= 1'b0;
            key_ready_q <= 1'b0;
            key_sig_q   <= 1'b0;
            ready_q     <= 1'b0;
            result_q    <= '0;
        end else begin
            key_sig_q <= 1'b0;
            if (key_load_acc) begin
                for (int i = 0; i < 4; i++) k_q[i] <= user_key_in[127-32*i -: 32] ^ FK[i];
                kcnt_q      <= '0;
                key_ready_q <= 1'b0;
            end else if (key_state_q == KEY_EXPAND) begin
                rk_q[kcnt_q] <= rk_new;
                k_q[0]       <= k_q[1];
                k_q[1]       <= k_q[2];
                k_q[2]       <= k_q[3];
                k_q[3]       <= rk_new;
                kcnt_q       <= kcnt_q + 5'd1;
                if (kcnt_q == 5'd31) begin
                    key_ready_q <= 1'b1;
                    key_sig_q   <= 1'b1;
                end
            end

            // RUN spends bcnt 0..31 on rounds and bcnt 32 publishing the result.
            if (start_acc) begin
                for (int i = 0; i < 4; i++) x_q[i] <= data_in[127-32*i -: 32];
                dec_q  <= encdec_sel_in;
                bcnt_q <= '0;
            end else if (blk_state_q == BLK_RUN) begin
                if (bcnt_q[5]) begin
                    result_q <= {x_q[3], x_q[2], x_q[1], x_q[0]};
                    ready_q  <= 1'b1;
                end else begin
                    x_q[0] <= x_q[1];
                    x_q[1] <= x_q[2];
                    x_q[2] <= x_q[3];
                    x_q[3] <= rnd_new;
                    bcnt_q <= bcnt_q + 6'd1;
                end
            end
            if (start_acc || key_load_acc) ready_q <= 1'b0;
        end
    end

    assign ready_out            = ready_q;
    assign result_out           = result_q;
    assign key_exp_ready_out    = key_ready_q;
    assign key_exp_ready_signal = key_sig_q;

endmodule

// File: tb/tb_sm4_top.sv
// Self-checking bench for sm4_top: independent SM4 reference model, vector table,
// expected-result queue and hand-written multi-cycle sequences.
module tb_sm4_top;

  localparam logic [2047:0] SB_FLAT = {
    128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };
  localparam logic [31:0] FK_T [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  localparam logic [127:0] KEY1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY2 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] PT1  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] CT1  = 128'h681EDF34D206965E86B3E94F536E4246;
  localparam logic [127:0] ONES = 128'h11111111111111111111111111111111;

  typedef struct {
    logic         sel;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         encdec_enable_in;
  logic         encdec_sel_in;
  logic         enable_key_exp_and_valid_data_in;
  logic [127:0] data_in;
  logic [127:0] user_key_in;
  logic         ready_out;
  logic [127:0] result_out;
  logic         key_exp_ready_out;
  logic         key_exp_ready_signal;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] exp_q[$];
  vec_t         vecs [6];
  logic [127:0] r1, r2, got;
  int           t0;
  bit           ok, seen;

  sm4_top dut (
    .clk                              (clk),
    .reset_n                          (reset_n),
    .encdec_enable_in                 (encdec_enable_in),
    .encdec_sel_in                    (encdec_sel_in),
    .enable_key_exp_and_valid_data_in (enable_key_exp_and_valid_data_in),
    .data_in                          (data_in),
    .user_key_in                      (user_key_in),
    .ready_out                        (ready_out),
    .result_out                       (result_out),
    .key_exp_ready_out                (key_exp_ready_out),
    .key_exp_ready_signal             (key_exp_ready_signal)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] x);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      b = x[8*j +: 8];
      r[8*j +: 8] = SB_FLAT[2047 - 8*int'(b) -: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] sm4_ref(input logic [127:0] key, input logic [127:0] blk,
                                           input bit dec);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] ckv, b, rk;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127-32*i -: 32] ^ FK_T[i];
      x[i] = blk[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      ckv = 0;
      for (int j = 0; j < 4; j++) ckv = (ckv << 8) | 32'(((4*i + j) * 7) % 256);
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckv);
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
    end
    for (int r = 0; r < 32; r++) begin
      rk = dec ? k[35-r] : k[r+4];
      b = tau(x[r+1] ^ x[r+2] ^ x[r+3] ^ rk);
      x[r+4] = x[r] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (ready_out) done = 1'b1;
    end
  endtask

  // driver: one block operation with keys already valid
  task automatic run_block(input string name, input bit sel, input logic [127:0] data,
                           input logic [127:0] exp, input int exp_lat);
    int          ts;
    bit          done;
    logic [127:0] e;
    encdec_sel_in = sel;
    data_in = data;
    encdec_enable_in = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    ts = cyc;
    encdec_enable_in = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    check({name, ".drop"}, 128'(ready_out), 128'd0);
    wait_ready(exp_lat + 10, done);
    check({name, ".lat"}, 128'(cyc - ts), 128'(exp_lat));
    e = exp_q.pop_front();
    check({name, ".result"}, result_out, e);
  endtask

  initial begin
    reset_n = 1'b1;
    encdec_enable_in = 1'b0;
    encdec_sel_in = 1'b0;
    enable_key_exp_and_valid_data_in = 1'b0;
    data_in = '0;
    user_key_in = '0;
    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 128'(ready_out), 128'd0);
    check("rst.key_ready", 128'(key_exp_ready_out), 128'd0);
    check("rst.key_sig", 128'(key_exp_ready_signal), 128'd0);
    check("rst.result", result_out, 128'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;

    // key-load, then a start two cycles later that must wait for the keys
    user_key_in = KEY1;
    enable_key_exp_and_valid_data_in = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    enable_key_exp_and_valid_data_in = 1'b0;
    user_key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    encdec_sel_in = 1'b0;
    data_in = PT1;
    encdec_enable_in = 1'b1;
    exp_q.push_back(CT1);
    @(posedge clk); #1;
    encdec_enable_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (key_exp_ready_signal) ok = 1'b1;
    end
    check("key.sig_lat", 128'(cyc - t0), 128'd32);
    check("key.ready", 128'(key_exp_ready_out), 128'd1);
    check("key.rk0", 128'(dut.rk_q[0]), 128'h F12186F9);
    check("key.rk31", 128'(dut.rk_q[31]), 128'h9124A012);
    @(posedge clk); #1;
    check("key.sig_pulse", 128'(key_exp_ready_signal), 128'd0);
    wait_ready(80, ok);
    check("enc_wait.lat", 128'(cyc - t0), 128'd66);
    got = exp_q.pop_front();
    check("enc_wait.result", result_out, got);

    // vector table under KEY1
    vecs[0] = '{1'b1, CT1, PT1};
    vecs[1] = '{1'b0, ONES, sm4_ref(KEY1, ONES, 1'b0)};
    vecs[2] = '{1'b1, sm4_ref(KEY1, ONES, 1'b0), ONES};
    vecs[3] = '{1'b0, r1, sm4_ref(KEY1, r1, 1'b0)};
    vecs[4] = '{1'b1, r2, sm4_ref(KEY1, r2, 1'b1)};
    vecs[5] = '{1'b0, PT1, CT1};
    for (int i = 0; i < 6; i++) begin
      run_block($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].exp, 33);
    end

    // start pulse during RUN is ignored
    encdec_sel_in = 1'b0;
    data_in = r1;
    encdec_enable_in = 1'b1;
    exp_q.push_back(sm4_ref(KEY1, r1, 1'b0));
    @(posedge clk); #1;
    t0 = cyc;
    encdec_enable_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    encdec_sel_in = 1'b1;
    data_in = r2;
    encdec_enable_in = 1'b1;
    @(posedge clk); #1;
    encdec_enable_in = 1'b0;
    wait_ready(60, ok);
    check("ign_start.lat", 128'(cyc - t0), 128'd33);
    got = exp_q.pop_front();
    check("ign_start.result", result_out, got);

    // key-load during RUN is ignored
    encdec_sel_in = 1'b0;
    data_in = ONES;
    encdec_enable_in = 1'b1;
    exp_q.push_back(sm4_ref(KEY1, ONES, 1'b0));
    @(posedge clk); #1;
    t0 = cyc;
    encdec_enable_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    user_key_in = KEY2;
    enable_key_exp_and_valid_data_in = 1'b1;
    @(posedge clk); #1;
    enable_key_exp_and_valid_data_in = 1'b0;
    wait_ready(60, ok);
    check("ign_key.lat", 128'(cyc - t0), 128'd33);
    check("ign_key.key_ready", 128'(key_exp_ready_out), 128'd1);
    got = exp_q.pop_front();
    check("ign_key.result", result_out, got);

    // simultaneous key-load and start from DONE: block waits for the new keys
    user_key_in = KEY2;
    enable_key_exp_and_valid_data_in = 1'b1;
    encdec_sel_in = 1'b0;
    data_in = r2;
    encdec_enable_in = 1'b1;
    exp_q.push_back(sm4_ref(KEY2, r2, 1'b0));
    @(posedge clk); #1;
    t0 = cyc;
    enable_key_exp_and_valid_data_in = 1'b0;
    encdec_enable_in = 1'b0;
    check("simul.key_ready_drop", 128'(key_exp_ready_out), 128'd0);
    check("simul.ready_drop", 128'(ready_out), 128'd0);
    wait_ready(90, ok);
    check("simul.lat", 128'(cyc - t0), 128'd66);
    got = exp_q.pop_front();
    check("simul.result", result_out, got);

    // round keys persist: decrypt with no re-expansion
    run_block("persist", 1'b1, sm4_ref(KEY2, r2, 1'b0), r2, 33);

    // reset mid-RUN aborts; a later start without key-load never completes
    encdec_sel_in = 1'b0;
    data_in = r1;
    encdec_enable_in = 1'b1;
    @(posedge clk); #1;
    encdec_enable_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst.ready", 128'(ready_out), 128'd0);
    check("midrst.key_ready", 128'(key_exp_ready_out), 128'd0);
    check("midrst.key_sig", 128'(key_exp_ready_signal), 128'd0);
    check("midrst.result", result_out, 128'd0);
    reset_n = 1'b0;
    data_in = r2;
    encdec_enable_in = 1'b1;
    @(posedge clk); #1;
    encdec_enable_in = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (ready_out) seen = 1'b1;
    end
    check("midrst.wait_key", 128'(seen), 128'd0);
    check("midrst.result_hold", result_out, 128'd0);
    check("sb.empty", 128'(exp_q.size()), 128'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_top.md
Name: sm4_top

Overview:
- Iterative SM4 (GB/T 32907) 128-bit block cipher engine with an on-chip key schedule.
- A key-load pulse latches a 128-bit user key and expands it into 32 round keys, one per cycle.
- An encrypt/decrypt start pulse then processes one 128-bit block in 32 rounds, one round per cycle.
- Sits as a leaf crypto accelerator behind a simple pulse/level handshake.

Parameters:
- none (SM4 fixes block, key and round count at 128/128/32)

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  synchronous reset, active-high (asserted = 1).
- encdec_enable_in  in  1  one-cycle start pulse for a block operation.
- encdec_sel_in  in  1  0 = encrypt, 1 = decrypt; sampled with the start pulse.
- enable_key_exp_and_valid_data_in  in  1  one-cycle pulse; latches user_key_in and starts key expansion.
- data_in  in  128  input block; sampled when a start pulse is accepted.
- user_key_in  in  128  user key; sampled with the key-load pulse.
- ready_out  out  1  level; high while result_out holds a valid result.
- result_out  out  128  result block, held until the next operation completes.
- key_exp_ready_out  out  1  level; high while all 32 round keys are valid.
- key_exp_ready_signal  out  1  one-cycle pulse in the cycle key expansion completes.

Behaviour:
- Reset (reset_n=1 at an edge): all outputs 0, round-key store 0, both FSMs IDLE, pending request cleared. Reset aborts any in-flight operation; no partial result is ever flagged ready.
- Key FSM states: IDLE, EXPAND.
  - Key-load pulse in IDLE, with the block FSM not RUN: latch MK = user_key_in; K0..K3 = MK xor FK, where FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Key-load also clears key_exp_ready_out and ready_out.
  - Key-load is ignored while in EXPAND or while the block FSM is in RUN.
  - EXPAND runs 32 cycles. Cycle i computes rk_i = K_i xor T'(K_{i+1} xor K_{i+2} xor K_{i+3} xor CK_i) and stores rk_i in slot i.
  - CK_i byte j (MSB first) = ((4i+j)*7) mod 256.
  - After rk_31 is stored: key_exp_ready_out=1 (held until next key-load or reset), key_exp_ready_signal pulses 1 cycle, return to IDLE.
- Block FSM states: IDLE, WAIT_KEY, RUN, DONE.
  - Start pulse in IDLE or DONE: latch data_in as X0..X3 (X0 = bits 127:96), latch encdec_sel_in, drop ready_out to 0.
  - Next state is RUN if key_exp_ready_out=1, else WAIT_KEY.
  - WAIT_KEY leaves for RUN the cycle after key_exp_ready_out rises. A start pulse 2 cycles after a key-load must be honoured this way.
  - Start pulses while in WAIT_KEY or RUN are ignored.
  - RUN lasts 32 cycles. Round r: X_{r+4} = X_r xor T(X_{r+1} xor X_{r+2} xor X_{r+3} xor rk). rk = rk_r for encrypt, rk_{31-r} for decrypt.
  - After round 31: result_out = {X35, X34, X33, X32}, ready_out=1, enter DONE.
  - ready_out stays 1 in DONE until the next accepted start, key-load, or reset.
- Latency with keys ready: ready_out rises 33 cycles after the cycle the start pulse is sampled.
- Transform definitions:
  - tau = SM4 S-box applied to each of the 4 bytes.
  - T = L(tau(x)), with L(B) = B^(B<<<2)^(B<<<10)^(B<<<18)^(B<<<24).
  - T' = L'(tau(x)), with L'(B) = B^(B<<<13)^(B<<<23).
  - All rotates are 32-bit circular.
- Simultaneous key-load and start pulse in the same cycle (block FSM IDLE/DONE): both accepted. The block goes to WAIT_KEY and uses the new keys.
- Round keys persist across blocks; repeated operations need no re-expansion.

Decomposition:
- Package sm4_pkg holds:
  - FK constants and a CK_i function.
  - The 256-entry S-box as a function/constant.
  - The L and L' functions and FSM state typedefs.
- Sub-module sm4_sbox: 8-bit combinational S-box, instantiated 4x for the round datapath and 4x for the key datapath.
- Round-key store is 32x32 registers inside sm4_top.

Test Plan:
- Reset held 2 cycles -> ready_out, key_exp_ready_out, key_exp_ready_signal, result_out all 0.
- Key-load pulse with key 0123456789ABCDEFFEDCBA9876543210 -> key_exp_ready_signal pulses once, exactly 32 cycles after the pulse is sampled. rk_0 = F12186F9, rk_31 = 9124A012.
- Start pulse with encdec_sel_in=0, data_in=0123456789ABCDEFFEDCBA9876543210, 2 cycles after key-load -> WAIT_KEY then RUN; result_out = 681EDF34D206965E86B3E94F536E4246 with ready_out=1.
- Decrypt: encdec_sel_in=1, data_in=681EDF34D206965E86B3E94F536E4246 -> ready_out drops the cycle after start, rises 33 cycles later; result_out = 0123456789ABCDEFFEDCBA9876543210.
- Same key, encrypt 11111111111111111111111111111111 -> result matches the software SM4 model; decrypting that result returns all-1s nibbles. Also repeat the 0123... vector 1,000,000 times -> 595298C7C6FD271F0402F804C33D3F66.
- Reset asserted mid-RUN -> all outputs 0 next cycle; a subsequent start without key-load waits in WAIT_KEY indefinitely (ready_out stays 0).
